// File: rtl/seq_feed_arb.sv
// Two-requester round-robin arbiter that serializes words MSB first into a
// sequence detector and credits detector hits to the requester being served.
module seq_feed_arb #(
  parameter int WORD_W    = 8,
  parameter int CLR_CYC   = 1,
  parameter int DRAIN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              det_data,
  output logic              det_valid,
  output logic              det_clr,
  input  logic              det_result,
  input  logic              cnt_clr,
  output logic [7:0]        hit_cnt0,
  output logic [7:0]        hit_cnt1,
  output logic              busy,
  output logic              owner
);

  localparam int CW = 6;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              lg_q, lg_d;
  logic              det_data_q, det_data_d;
  logic              det_valid_q, det_valid_d;
  logic              det_clr_q, det_clr_d;
  logic              busy_q, busy_d;
  logic [7:0]        hc0_q, hc0_d;
  logic [7:0]        hc1_q, hc1_d;

  logic idle;
  logic gnt1;
  logic hs;
  logic hit;

  always_comb begin
    idle = (state_q == IDLE) && !rst;
    gnt1 = req1_valid && (!req0_valid || !lg_q);
    hs   = idle && (req0_valid || req1_valid);

    req0_ready = idle && req0_valid && !gnt1;
    req1_ready = idle && gnt1;

    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    lg_d    = lg_q;

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = CLEAR;
          sh_d    = gnt1 ? req1_data : req0_data;
          owner_d = gnt1;
          lg_d    = gnt1;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == CW'(CLR_CYC - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(WORD_W - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state; the MSB leaves as we shift.
    det_valid_d = (state_d == SHIFT);
    det_clr_d   = (state_d == CLEAR);
    busy_d      = (state_d != IDLE);
    det_data_d  = 1'b0;
    if (state_d == SHIFT) begin
      det_data_d = sh_q[WORD_W-1];
      sh_d       = {sh_q[WORD_W-2:0], 1'b0};
    end

    hit   = det_result && ((state_q == SHIFT) || (state_q == DRAIN));
    hc0_d = hc0_q;
    hc1_d = hc1_q;
    if (cnt_clr) begin
      hc0_d = '0;
      hc1_d = '0;
    end else if (hit) begin
      if (!owner_q && hc0_q != 8'hFF) hc0_d = hc0_q + 8'd1;
      if (owner_q && hc1_q != 8'hFF)  hc1_d = hc1_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      lg_q        <= 1'b1;
      det_data_q  <= 1'b0;
      det_valid_q <= 1'b0;
      det_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      hc0_q       <= '0;
      hc1_q       <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      lg_q        <= lg_d;
      det_data_q  <= det_data_d;
      det_valid_q <= det_valid_d;
      det_clr_q   <= det_clr_d;
      busy_q      <= busy_d;
      hc0_q       <= hc0_d;
      hc1_q       <= hc1_d;
    end
  end

  assign det_data  = det_data_q;
  assign det_valid = det_valid_q;
  assign det_clr   = det_clr_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign hit_cnt0  = hc0_q;
  assign hit_cnt1  = hc1_q;

endmodule

// File: doc/seq_feed_arb.md
SEQ_FEED_ARB -- requirements
Module: seq_feed_arb

Interface
REQ-001 Parameter WORD_W, default 8: bits per serialized word; legal range 2..32.
REQ-002 Parameter CLR_CYC, default 1: cycles det_clr is held before each word; legal range 1..15.
REQ-003 Parameter DRAIN_CYC, default 1: cycles after the last bit during which det_result is still credited to the owner; legal range 1..15.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req0_valid  in  1  requester 0 has a word.
REQ-007 req0_data  in  WORD_W  requester 0 word, sent MSB first.
REQ-008 req0_ready  out  1  requester 0 word accepted when req0_valid && req0_ready.
REQ-009 req1_valid / req1_data / req1_ready  in / in / out  1 / WORD_W / 1  same as requester 0.
REQ-010 det_data  out  1  serial bit to the sequence detector's i_data.
REQ-011 det_valid  out  1  det_data qualifier to the detector's valid.
REQ-012 det_clr  out  1  active-high clear of the detector history; the integrator inverts it for the detector's rst_n.
REQ-013 det_result  in  1  detector match pulse.
REQ-014 cnt_clr  in  1  synchronous clear of both hit counters.
REQ-015 hit_cnt0 / hit_cnt1  out  8 / 8  saturating match counts per requester.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 owner  out  1  requester currently served; holds the last owner while in IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, CLEAR, SHIFT and DRAIN.
REQ-019 In IDLE, req0_ready/req1_ready SHALL be driven combinationally from the arbitration result; both ready outputs SHALL be 0 in every other state.
REQ-020 Arbitration SHALL be round-robin:
- only one valid: that requester is granted;
- both valid: the requester not equal to last_grant is granted;
- last_grant resets to 1, so requester 0 wins the first tie.
REQ-021 On the handshake, the block SHALL latch the word into a WORD_W shift register, set owner and last_grant to the granted index, and enter CLEAR on the next cycle.
REQ-022 In CLEAR, det_clr SHALL be 1 for exactly CLR_CYC cycles and det_valid SHALL be 0; the state then moves to SHIFT.
REQ-023 In SHIFT, det_valid SHALL be 1 for exactly WORD_W consecutive cycles, with det_data = word[WORD_W-1-k] on the k-th cycle; the state then moves to DRAIN.
REQ-024 In DRAIN, det_valid and det_clr SHALL be 0 for DRAIN_CYC cycles; the state then returns to IDLE.
REQ-025 Back-to-back words SHALL be possible: the first IDLE cycle after DRAIN may handshake.
REQ-026 Minimum per-word period SHALL be 1+CLR_CYC+WORD_W+DRAIN_CYC cycles.
REQ-027 det_data SHALL be 0 whenever det_valid is 0.
REQ-028 det_result=1 sampled in SHIFT or DRAIN SHALL increment the owner's counter by 1 on the next edge.
REQ-029 det_result sampled in IDLE or CLEAR SHALL be ignored.
REQ-030 Counters SHALL saturate at 255 and not wrap.
REQ-031 If cnt_clr and a counted hit occur in the same cycle, cnt_clr SHALL win and the counter becomes 0.
REQ-032 Requester inputs SHALL be ignored outside the IDLE handshake; a word already latched is unaffected by later input changes.

Reset
REQ-033 When rst=1 at a rising edge, the block SHALL set, on that edge:
- state IDLE, owner 0, last_grant 1;
- det_data 0, det_valid 0, det_clr 0;
- hit_cnt0 0, hit_cnt1 0, busy 0;
- shift register and bit/cycle counters 0.
REQ-034 Reset asserted mid-word SHALL abort the word with no further det_valid cycles and no retry; the requester must resubmit.
REQ-035 While rst=1, both ready outputs SHALL be 0.

Verification
REQ-036 Single word: defaults, req0 presents 8'hB2 for one cycle -> req0_ready=1 that cycle, det_clr=1 for 1 cycle, det_valid=1 for 8 cycles carrying 1,0,1,1,0,0,1,0, busy=1 for 10 cycles, owner=0.
REQ-037 Tie: both requesters valid continuously after reset -> grants alternate 0,1,0,1, each word period 11 cycles with no IDLE gap beyond 1 cycle.
REQ-038 Hit attribution: det_result pulses on the 8th SHIFT cycle and in DRAIN of a req1 word -> hit_cnt1 increments by 2 and hit_cnt0 is unchanged; a pulse in CLEAR is not counted.
REQ-039 Saturation/clear: 300 hits for req0 -> hit_cnt0=255; cnt_clr coincident with a hit -> hit_cnt0=0.
REQ-040 Reset mid-operation: rst=1 on SHIFT cycle 4 -> next cycle det_valid=0, busy=0, counters 0; the next tie grants req0.
